// File: rtl/rescale_sequencer_pkg.sv
// rtl/rescale_sequencer_pkg.sv - shared types and constants for the rescale sequencer
package rescale_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SEARCH,
        ST_LATCH,
        ST_NORM,
        ST_SCALE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int NB_OUT  = 8;
    localparam int OUT_MAX = (1 << NB_OUT) - 1;
    localparam int SHIFT_W = 5;

endpackage

// File: rtl/rescale_datapath.sv
// rtl/rescale_datapath.sv - two-stage subtract / clamp / shift / saturate pixel pipeline
module rescale_datapath #(
    parameter int NB_PIXEL = 19,
    parameter int NB_OUT   = 8,
    parameter int SHIFT_W  = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_rdEn,
    input  logic signed [NB_PIXEL-1:0] i_rdData,
    input  logic signed [NB_PIXEL-1:0] i_min,
    input  logic [SHIFT_W-1:0]         i_shift,
    output logic [NB_OUT-1:0]          o_pixel,
    output logic                       o_pixelValid,
    output logic                       o_inflight
);

    localparam logic [NB_PIXEL:0] OUT_LIM = {{(NB_PIXEL + 1 - NB_OUT){1'b0}}, {NB_OUT{1'b1}}};

    logic                     data_valid_q;
    logic                     diff_valid_q;
    logic signed [NB_PIXEL:0] diff_q;
    logic [NB_PIXEL:0]        mag;
    logic [NB_OUT-1:0]        pixel_d;

    // Second stage: negative differences clamp to zero, large magnitudes saturate.
    always_comb begin
        mag = $unsigned(diff_q) >> i_shift;
        if (diff_q[NB_PIXEL]) begin
            pixel_d = '0;
        end else if (mag > OUT_LIM) begin
            pixel_d = '1;
        end else begin
            pixel_d = mag[NB_OUT-1:0];
        end
    end

    // Valid tracks read latency (1), subtract stage and output stage; data registers follow.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_valid_q <= 1'b0;
            diff_valid_q <= 1'b0;
            o_pixelValid <= 1'b0;
            diff_q       <= '0;
            o_pixel      <= '0;
        end else begin
            data_valid_q <= i_rdEn;
            diff_valid_q <= data_valid_q;
            o_pixelValid <= diff_valid_q;
            diff_q       <= {i_rdData[NB_PIXEL-1], i_rdData} - {i_min[NB_PIXEL-1], i_min};
            o_pixel      <= pixel_d;
        end
    end

    assign o_inflight = data_valid_q | diff_valid_q;

endmodule

// File: rtl/rescale_sequencer.sv
// rtl/rescale_sequencer.sv - two-pass search/rescale sequencing controller
module rescale_sequencer #(
    parameter int NB_PIXEL = 19,
    parameter int NB_COUNT = 32,
    parameter int NB_OUT   = rescale_sequencer_pkg::NB_OUT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic [NB_COUNT-1:0]        i_imageSize,
    input  logic                       i_convValid,
    output logic                       o_searchReset,
    output logic                       o_searchValid,
    input  logic signed [NB_PIXEL-1:0] i_maxValue,
    input  logic signed [NB_PIXEL-1:0] i_minValue,
    output logic                       o_rdEn,
    output logic [NB_COUNT-1:0]        o_rdAddr,
    input  logic signed [NB_PIXEL-1:0] i_rdData,
    output logic [NB_OUT-1:0]          o_pixel,
    output logic                       o_pixelValid,
    output logic [4:0]                 o_shift,
    output logic                       o_busy,
    output logic                       o_done
);

    import rescale_sequencer_pkg::*;

    // Largest shift that brings any NB_PIXEL+1-bit range into NB_OUT bits.
    localparam logic [SHIFT_W-1:0] SHIFT_LIM = SHIFT_W'(NB_PIXEL + 1 - NB_OUT);
    localparam logic [NB_PIXEL:0]  RANGE_LIM = {{(NB_PIXEL + 1 - NB_OUT){1'b0}}, {NB_OUT{1'b1}}};

    state_t                     state_q, state_d;
    logic [NB_COUNT-1:0]        size_q;
    logic [NB_COUNT-1:0]        count_q;
    logic [NB_COUNT-1:0]        addr_q;
    logic signed [NB_PIXEL-1:0] min_q;
    logic [NB_PIXEL:0]          range_q;
    logic [SHIFT_W-1:0]         shift_q;
    logic [NB_COUNT-1:0]        count_next;
    logic [NB_COUNT-1:0]        last_addr;
    logic                       norm_more;
    logic                       inflight;

    assign count_next = count_q + NB_COUNT'(1);
    assign last_addr  = size_q - NB_COUNT'(1);
    assign norm_more  = ((range_q >> shift_q) > RANGE_LIM) && (shift_q < SHIFT_LIM);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs decoded from the current state.
    always_comb begin
        state_d       = state_q;
        o_searchReset = 1'b0;
        o_searchValid = 1'b0;
        o_rdEn        = 1'b0;
        o_busy        = 1'b1;
        o_done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start && (i_imageSize != '0)) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                o_searchReset = 1'b1;
                state_d       = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (i_convValid && (count_next == size_q)) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                o_searchValid = 1'b1;
                state_d       = ST_NORM;
            end
            ST_NORM: begin
                if (!norm_more) begin
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                o_rdEn = 1'b1;
                if (addr_q == last_addr) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame size, pixel count, extremes, NORM shift search and read address.
    always_ff @(posedge clock) begin
        if (reset) begin
            size_q  <= '0;
            count_q <= '0;
            addr_q  <= '0;
            min_q   <= '0;
            range_q <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start && (i_imageSize != '0)) begin
                        size_q <= i_imageSize;
                    end
                end
                ST_CLEAR: begin
                    count_q <= '0;
                end
                ST_SEARCH: begin
                    if (i_convValid) begin
                        count_q <= count_next;
                    end
                end
                ST_LATCH: begin
                    min_q   <= i_minValue;
                    range_q <= {i_maxValue[NB_PIXEL-1], i_maxValue} - {i_minValue[NB_PIXEL-1], i_minValue};
                    shift_q <= '0;
                end
                ST_NORM: begin
                    if (norm_more) begin
                        shift_q <= shift_q + SHIFT_W'(1);
                    end else begin
                        addr_q <= '0;
                    end
                end
                ST_SCALE: begin
                    addr_q <= addr_q + NB_COUNT'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign o_rdAddr = o_rdEn ? addr_q : '0;
    assign o_shift  = 5'(shift_q);

    rescale_datapath #(
        .NB_PIXEL (NB_PIXEL),
        .NB_OUT   (NB_OUT),
        .SHIFT_W  (SHIFT_W)
    ) u_datapath (
        .clock        (clock),
        .reset        (reset),
        .i_rdEn       (o_rdEn),
        .i_rdData     (i_rdData),
        .i_min        (min_q),
        .i_shift      (shift_q),
        .o_pixel      (o_pixel),
        .o_pixelValid (o_pixelValid),
        .o_inflight   (inflight)
    );

endmodule

// File: tb/tb_rescale_sequencer.sv
// tb/tb_rescale_sequencer.sv - randomized self-checking bench for rescale_sequencer
module tb_rescale_sequencer;

    import rescale_sequencer_pkg::*;

    localparam int PW = 19;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 i_start = 1'b0;
    logic [31:0]          i_imageSize = '0;
    logic                 i_convValid = 1'b0;
    logic                 o_searchReset;
    logic                 o_searchValid;
    logic signed [PW-1:0] i_maxValue = '0;
    logic signed [PW-1:0] i_minValue = '0;
    logic                 o_rdEn;
    logic [31:0]          o_rdAddr;
    logic signed [PW-1:0] i_rdData = '0;
    logic [7:0]           o_pixel;
    logic                 o_pixelValid;
    logic [4:0]           o_shift;
    logic                 o_busy;
    logic                 o_done;

    int n_tests = 0;
    int n_fail  = 0;
    int mem [0:63];

    rescale_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .i_start       (i_start),
        .i_imageSize   (i_imageSize),
        .i_convValid   (i_convValid),
        .o_searchReset (o_searchReset),
        .o_searchValid (o_searchValid),
        .i_maxValue    (i_maxValue),
        .i_minValue    (i_minValue),
        .o_rdEn        (o_rdEn),
        .o_rdAddr      (o_rdAddr),
        .i_rdData      (i_rdData),
        .o_pixel       (o_pixel),
        .o_pixelValid  (o_pixelValid),
        .o_shift       (o_shift),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 clock = ~clock;

    // Frame buffer: synchronous read, data one cycle after the strobe.
    always @(posedge clock) begin
        if (o_rdEn) i_rdData <= PW'(mem[o_rdAddr[5:0]]);
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_shift(input int mn, input int mx);
        int rng = mx - mn;
        int sh = 0;
        while ((rng >> sh) > OUT_MAX && sh < PW + 1 - NB_OUT) sh++;
        return sh;
    endfunction

    function automatic int ref_pixel(input int v, input int mn, input int sh);
        int d = v - mn;
        int p;
        if (d < 0) return 0;
        p = d >> sh;
        return (p > OUT_MAX) ? OUT_MAX : p;
    endfunction

    // Start a frame, present n valids with the given spacing, and wait for the first read.
    task automatic feed_frame(input int n, input int gap, input int mn, input int mx, input string tag);
        bit sv_early = 0;
        int lat;
        int sh = ref_shift(mn, mx);
        i_minValue = PW'(mn);
        i_maxValue = PW'(mx);
        @(negedge clock);
        i_start = 1'b1;
        i_imageSize = n;
        @(negedge clock);
        i_start = 1'b0;
        check_eq({tag, ".clr"}, o_searchReset, 1);
        @(negedge clock);
        check_eq({tag, ".search"}, {o_searchReset, o_busy}, 2'b01);
        for (int k = 0; k < n; k++) begin
            repeat (gap - 1) begin
                @(negedge clock);
                sv_early |= o_searchValid;
            end
            i_convValid = 1'b1;
            @(negedge clock);
            i_convValid = 1'b0;
            if (k < n - 1) sv_early |= o_searchValid;
        end
        check_eq({tag, ".latch_early"}, sv_early, 0);
        check_eq({tag, ".latch"}, o_searchValid, 1);
        lat = 1;
        while (!o_rdEn && lat < 64) begin
            @(negedge clock);
            lat++;
        end
        check_eq({tag, ".rd_lat"}, lat, sh + 3);
        check_eq({tag, ".shift"}, o_shift, sh);
    endtask

    task automatic run_frame(input int n, input int gap, input int mn, input int mx,
                             input bit poke_start, input string tag);
        int exp_q[$];
        int sh = ref_shift(mn, mx);
        int cyc = 0, rd_err = 0, pv_cnt = 0, first_pv = -1, last_pv = -1, done_cyc = -1;
        for (int k = 0; k < n; k++) exp_q.push_back(ref_pixel(mem[k], mn, sh));
        feed_frame(n, gap, mn, mx, tag);
        while (done_cyc < 0 && cyc < n + 32) begin
            if (o_rdEn != (cyc < n) || (o_rdEn && o_rdAddr != 32'(cyc))) rd_err++;
            if (o_pixelValid) begin
                if (first_pv < 0) first_pv = cyc;
                last_pv = cyc;
                pv_cnt++;
                if (exp_q.size() > 0) check_eq({tag, ".pix"}, o_pixel, exp_q.pop_front());
            end
            if (o_done) done_cyc = cyc;
            if (poke_start && cyc == 1) begin
                i_start = 1'b1;
                i_imageSize = 3;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        i_start = 1'b0;
        check_eq({tag, ".rd_seq"}, rd_err, 0);
        check_eq({tag, ".pv_count"}, pv_cnt, n);
        check_eq({tag, ".pv_first"}, first_pv, 3);
        check_eq({tag, ".done_at"}, done_cyc, last_pv + 1);
        check_eq({tag, ".idle_after"}, {o_done, o_busy}, 2'b00);
    endtask

    initial begin
        int n, gap, mn, mx, amp;
        repeat (3) @(negedge clock);
        check_eq("rst.ctrl", {o_searchReset, o_searchValid, o_rdEn, o_pixelValid, o_busy, o_done}, 0);
        check_eq("rst.addr", o_rdAddr, 0);
        check_eq("rst.pix", {o_pixel, o_shift}, 0);
        reset = 1'b0;

        // Size 0 request is ignored.
        @(negedge clock);
        i_start = 1'b1;
        i_imageSize = 0;
        @(negedge clock);
        i_start = 1'b0;
        check_eq("size0.busy", {o_busy, o_searchReset}, 2'b00);

        mem[0] = 10; mem[1] = -6; mem[2] = 100; mem[3] = 50;
        run_frame(4, 1, -6, 100, 1'b0, "basic");

        mem[0] = 0; mem[1] = 1000; mem[2] = 3; mem[3] = 500;
        run_frame(4, 1, 0, 1000, 1'b0, "shift2");

        for (int k = 0; k < 6; k++) mem[k] = 7;
        run_frame(6, 1, 7, 7, 1'b0, "flat");

        for (int k = 0; k < 5; k++) mem[k] = k * 37 - 20;
        run_frame(5, 3, -20, 128, 1'b0, "gaps");

        // Extremes narrower than the stored data: clamp-to-zero and saturation.
        mem[0] = -50; mem[1] = 500; mem[2] = 100; mem[3] = 37;
        run_frame(4, 1, 0, 100, 1'b1, "sat_poke");

        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 20);
            gap = $urandom_range(1, 3);
            amp = 1 << $urandom_range(0, 18);
            mn = 1 << 30;
            mx = -(1 << 30);
            for (int k = 0; k < n; k++) begin
                mem[k] = int'($urandom_range(0, 2 * amp - 1)) - amp;
                if (mem[k] < mn) mn = mem[k];
                if (mem[k] > mx) mx = mem[k];
            end
            run_frame(n, gap, mn, mx, f[0], $sformatf("rnd%0d", f));
        end

        // Reset in the middle of SCALE discards the frame.
        for (int k = 0; k < 8; k++) mem[k] = k * 3;
        feed_frame(8, 1, 0, 21, "rstmid");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rstmid.outs", {o_rdEn, o_pixelValid, o_busy, o_done, o_searchValid}, 0);
        check_eq("rstmid.regs", {o_rdAddr, o_pixel, o_shift}, 0);
        reset = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clock);
            if (o_pixelValid || o_done || o_rdEn) n++;
        end
        check_eq("rstmid.quiet", n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
